fetch_pc_gen: RTL and testbench

Fetch-stage PC generator and instruction-request sequencer that sits directly upstream of branch_predictor. It drives fetch_pc into the predictor's PC input and consumes the predictor's predicted_pc/predict_taken and the execute-stage flush. It issues one outstanding request at a time to instruction memory over a valid/ready interface. Returned instructions go to decode through a registered output slot backed by a one-entry skid buffer.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_skid_buf.sv | 45 ++++
 rtl/fetch_pc_gen.sv | 193 +++++++++++++++++++
 tb/tb_fetch_pc_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC generator: FSM state codes, reset and
// step defaults, the {pc, instr} entry carried to decode, and the redirect
// target selection used by the sequencer.
package fetch_pkg;

  // Default PC after reset and the sequential fetch increment.
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FETCH_PC_STEP  = 32'd4;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // The execute-stage flush always overrides the predictor.
  function automatic logic [31:0] redirect_target(
    input logic        flush,
    input logic [31:0] flush_pc,
    input logic [31:0] pred_pc
  );
    return flush ? flush_pc : pred_pc;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for a fetched {pc, instr} pair. It catches a
// response that arrives while decode is still stalled on the previous
// instruction. Flush wins over load, load wins over drain.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  fetch_entry_t data_q;
  logic         full_q;

  // Occupancy tracking: flush discards, load fills, drain empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
    end else if (flush) begin
      full_q <= 1'b0;
    end else if (load) begin
      full_q <= 1'b1;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  // Payload capture; contents are only meaningful while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load && !flush) begin
      data_q <= din;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator and instruction-request sequencer. Keeps one
// request outstanding to instruction memory, follows predictor and execute
// redirects, and hands returned instructions to decode through a registered
// output slot backed by a one-entry skid buffer.
//
// Handshakes: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high; while valid is high and ready low the
// address is held unchanged. Responses are always accepted. The decode
// slot transfers on a cycle where if_valid is high and stall is low; while
// stalled the slot contents are held unchanged.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] PC_STEP  = FETCH_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic        ex_flush,
  input  logic [31:0] ex_redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] fetch_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [1:0]  dbg_state
);

  logic [1:0]   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic [31:0]  redir_q, redir_d;
  logic [31:0]  req_addr_q;

  logic         if_valid_q;
  fetch_entry_t if_entry_q;

  logic         redirect;
  logic [31:0]  target;
  logic         req_hs;
  logic         slot_free;
  logic [31:0]  aligned_pc;

  logic         skid_load;
  logic         skid_drain;
  logic         skid_full;
  fetch_entry_t skid_dout;
  fetch_entry_t resp_entry;
  logic         out_load_resp;
  logic         out_load_skid;

  assign redirect   = ex_flush | pred_taken;
  assign target     = redirect_target(ex_flush, ex_redirect_pc, pred_pc);
  assign req_hs     = (state_q == ST_REQ) && imem_req_ready;
  assign slot_free  = !if_valid_q || !stall;
  assign aligned_pc = {pc_q[31:2], 2'b00};
  assign resp_entry = '{pc: req_addr_q, instr: imem_resp_data};

  // Next-state, PC and kill bookkeeping for the request sequencer.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    redir_d       = redir_q;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;
    out_load_resp = 1'b0;
    out_load_skid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect) pc_d = target;
      end
      ST_REQ: begin
        // A redirect cannot retract a presented request, so it is
        // remembered and the resulting response is thrown away later.
        if (redirect) begin
          kill_d  = 1'b1;
          redir_d = target;
        end
        if (imem_req_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          kill_d  = 1'b1;
          redir_d = target;
          if (imem_resp_valid) begin
            // Outstanding request resolves now: drop it and go straight
            // to the new target.
            pc_d    = target;
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end
        end else if (imem_resp_valid) begin
          state_d = ST_REQ;
          if (kill_q) begin
            pc_d   = redir_q;
            kill_d = 1'b0;
          end else if (slot_free) begin
            out_load_resp = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = ST_REQ;
        end else if (!stall) begin
          skid_drain    = 1'b1;
          out_load_skid = 1'b1;
          state_d       = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      redir_q <= redir_d;
    end
  end

  // Address of the accepted request, used to tag its returning instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr_q <= '0;
    end else if (req_hs) begin
      req_addr_q <= aligned_pc;
    end
  end

  // Decode output slot: redirect invalidates, new data loads, a consumed
  // entry with nothing behind it empties the slot, a stall holds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_entry_q <= '0;
    end else if (redirect) begin
      if_valid_q <= 1'b0;
    end else if (out_load_resp) begin
      if_valid_q <= 1'b1;
      if_entry_q <= resp_entry;
    end else if (out_load_skid && skid_full) begin
      if_valid_q <= 1'b1;
      if_entry_q <= skid_dout;
    end else if (!stall) begin
      if_valid_q <= 1'b0;
    end
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .drain (skid_drain),
    .flush (redirect),
    .din   (resp_entry),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = imem_req_valid ? aligned_pc : 32'h0;
  assign fetch_pc       = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_entry_q.pc;
  assign if_instr       = if_entry_q.instr;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: an instruction-memory responder, a decode
// consumer with an expected-instruction queue, and per-cycle output checks.
module tb_fetch_pc_gen;
  import fetch_pkg::*;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pred_pc = '0;
  logic        pred_taken = 1'b0;
  logic        ex_flush = 1'b0;
  logic [31:0] ex_redirect_pc = '0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] fetch_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic auto_resp = 1'b1;
  logic drop_resp = 1'b0;

  fetch_pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .pred_pc         (pred_pc),
    .pred_taken      (pred_taken),
    .ex_flush        (ex_flush),
    .ex_redirect_pc  (ex_redirect_pc),
    .stall           (stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .fetch_pc        (fetch_pc),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .dbg_state       (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock. Called at a negedge with inputs set up; consumes the
  // decode slot, then plays instruction memory for a request accepted at
  // this edge (one-cycle response, data = addr ^ 0xA5A5_0000).
  task automatic tick();
    logic         hs;
    logic [31:0]  a;
    logic [W-1:0] e;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    if (if_valid && !stall) begin
      if (exp_q.size() == 0) begin
        check("unexpected_if_valid", {31'b0, if_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e[63:32]);
        check("if_instr", if_instr, e[31:0]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    ex_flush   = 1'b0;
    pred_taken = 1'b0;
    if (hs && auto_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = a ^ 32'hA5A5_0000;
      if (!drop_resp) exp_q.push_back({a, a ^ 32'hA5A5_0000});
      drop_resp = 1'b0;
    end else begin
      imem_resp_valid = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    // Reset state.
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    rst = 1'b0;
    imem_req_ready = 1'b1;
    check("idle_req_valid", {31'b0, imem_req_valid}, 32'd0);

    // Sequential fetch 0x0, 0x4, 0x8.
    tick();
    check("req0_valid", {31'b0, imem_req_valid}, 32'd1);
    check("req0_addr", imem_req_addr, 32'h0);
    check("req0_fetch_pc", fetch_pc, 32'h0);
    tick();
    check("after_acc0_fetch_pc", fetch_pc, 32'h4);
    tick();
    check("req1_addr", imem_req_addr, 32'h4);
    tick();
    check("after_acc1_fetch_pc", fetch_pc, 32'h8);
    tick();

    // Memory backpressure at 0x8 while decode stalls on 0x4.
    imem_req_ready = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("bp_req_addr", imem_req_addr, 32'h8);
      check("bp_fetch_pc", fetch_pc, 32'h8);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    tick();
    // Response for 0x8 landed in the skid buffer.
    check("hold_state", {30'b0, dbg_state}, {30'b0, ST_HOLD});
    check("hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("hold_if_valid", {31'b0, if_valid}, 32'd1);
    check("hold_if_pc", if_pc, 32'h4);
    tick();
    check("hold2_state", {30'b0, dbg_state}, {30'b0, ST_HOLD});
    check("hold2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    stall = 1'b0;
    tick();
    check("skid_out_if_pc", if_pc, 32'h8);
    check("after_hold_req_addr", imem_req_addr, 32'hC);
    tick();
    tick();

    // Flush in WAIT for 0x10 with the response in the same cycle.
    check("req_0x10_addr", imem_req_addr, 32'h10);
    drop_resp = 1'b1;
    tick();
    check("flush_wait_state", {30'b0, dbg_state}, {30'b0, ST_WAIT});
    ex_flush = 1'b1;
    ex_redirect_pc = 32'h100;
    tick();
    check("flush_if_valid", {31'b0, if_valid}, 32'd0);
    check("flush_req_addr", imem_req_addr, 32'h100);
    check("flush_fetch_pc", fetch_pc, 32'h100);

    // Flush beats prediction; redirect in REQ without handshake.
    imem_req_ready = 1'b0;
    pred_taken = 1'b1;
    pred_pc = 32'h200;
    ex_flush = 1'b1;
    ex_redirect_pc = 32'h300;
    tick();
    check("kill_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("kill_req_addr", imem_req_addr, 32'h100);
    imem_req_ready = 1'b1;
    drop_resp = 1'b1;
    tick();
    tick();
    check("prio_req_addr", imem_req_addr, 32'h300);
    check("prio_if_valid", {31'b0, if_valid}, 32'd0);
    tick();
    tick();

    // Redirect with handshake to 0xFFFF_FFFC, then wrap.
    check("req_0x304_addr", imem_req_addr, 32'h304);
    ex_flush = 1'b1;
    ex_redirect_pc = 32'hFFFF_FFFC;
    drop_resp = 1'b1;
    tick();
    check("redir_hs_if_valid", {31'b0, if_valid}, 32'd0);
    tick();
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_pre_fetch_pc", fetch_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_fetch_pc", fetch_pc, 32'h0);
    tick();
    auto_resp = 1'b0;
    tick();

    // Asynchronous reset in the middle of WAIT.
    check("pre_rst_state", {30'b0, dbg_state}, {30'b0, ST_WAIT});
    check("pre_rst_fetch_pc", fetch_pc, 32'h4);
    #2 rst = 1'b1;
    #1;
    check("arst_fetch_pc", fetch_pc, 32'h0);
    check("arst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    check("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("arst_if_valid", {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h1234_5678;
    check("post_rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    tick();
    check("late_resp_if_valid", {31'b0, if_valid}, 32'd0);
    check("post_rst_req_addr", imem_req_addr, 32'h0);

    // Run two more fetches, then drain.
    auto_resp = 1'b1;
    repeat (4) tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() != 0 || if_valid) tick();
    end
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
